// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between NREQ requesters. One operation
// is in flight at a time: IDLE grants a requester (round robin), EXEC gives the
// ALU one cycle on registered operands, RESP presents the captured result until
// the consumer takes it.
//
// Handshake rules (both sides):
//   - A transfer happens on a rising CLK edge where valid and ready are both 1.
//   - Request side: requester i holds req_valid[i] and its fields stable until
//     it sees req_ready[i]=1. req_ready is a one-hot pulse in IDLE only.
//   - Response side: rsp_valid and all rsp_* hold stable until rsp_ready=1.
//     rsp_ready has no effect while rsp_valid is 0.
//
// Ports:
//   CLK, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (NREQ bits)
//   req_rs1/rs2       packed operands, requester i at [i*XLEN +: XLEN]
//   req_alu_ctrl/funct3 packed 3-bit controls, requester i at [i*3 +: 3]
//   req_funct7_5/sub  per-requester control bits
//   alu_*  (out)      registered operands/controls driving the ALU
//   alu_result/overflow (in) ALU outputs, captured at the end of EXEC
//   rsp_valid/ready   response handshake
//   rsp_id/result/overflow response payload
//   busy              state is not IDLE
//   dbg_state         current FSM state (0=IDLE, 1=EXEC, 2=RESP)
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_rs1,
  input  logic [NREQ*XLEN-1:0] req_rs2,
  input  logic [NREQ*3-1:0]    req_alu_ctrl,
  input  logic [NREQ*3-1:0]    req_funct3,
  input  logic [NREQ-1:0]      req_funct7_5,
  input  logic [NREQ-1:0]      req_sub,
  output logic [XLEN-1:0]      alu_rs1,
  output logic [XLEN-1:0]      alu_rs2,
  output logic [2:0]           alu_ctrl,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7_5,
  output logic                 alu_sub,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 rsp_overflow,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [XLEN-1:0] alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0] alu_rs2_q, alu_rs2_d;
  logic [2:0]      alu_ctrl_q, alu_ctrl_d;
  logic [2:0]      alu_funct3_q, alu_funct3_d;
  logic            alu_funct7_5_q, alu_funct7_5_d;
  logic            alu_sub_q, alu_sub_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_overflow_q, rsp_overflow_d;

  // Round-robin pick: the lowest valid index at or above ptr wins; if none,
  // wrap to the lowest valid index overall.
  logic           found_hi, found_any;
  logic [IDW-1:0] idx_hi, idx_any, gnt_idx;

  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !found_any) begin
        found_any = 1'b1;
        idx_any   = IDW'(i);
      end
      if (req_valid[i] && !found_hi && (IDW'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = IDW'(i);
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_any;
  end

  // Selected requester fields (constant-index mux keeps widths explicit).
  logic [XLEN-1:0] sel_rs1, sel_rs2;
  logic [2:0]      sel_ctrl, sel_funct3;
  logic            sel_funct7_5, sel_sub;

  always_comb begin
    sel_rs1      = '0;
    sel_rs2      = '0;
    sel_ctrl     = '0;
    sel_funct3   = '0;
    sel_funct7_5 = 1'b0;
    sel_sub      = 1'b0;
    req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_rs1      = req_rs1[i*XLEN +: XLEN];
        sel_rs2      = req_rs2[i*XLEN +: XLEN];
        sel_ctrl     = req_alu_ctrl[i*3 +: 3];
        sel_funct3   = req_funct3[i*3 +: 3];
        sel_funct7_5 = req_funct7_5[i];
        sel_sub      = req_sub[i];
        req_ready[i] = (state_q == IDLE) && found_any;
      end
    end
  end

  // Next-state logic. All registers default to holding, so the alu_* port
  // stays quiet between grants.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    alu_rs1_d      = alu_rs1_q;
    alu_rs2_d      = alu_rs2_q;
    alu_ctrl_d     = alu_ctrl_q;
    alu_funct3_d   = alu_funct3_q;
    alu_funct7_5_d = alu_funct7_5_q;
    alu_sub_d      = alu_sub_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    case (state_q)
      IDLE: begin
        if (found_any) begin
          alu_rs1_d      = sel_rs1;
          alu_rs2_d      = sel_rs2;
          alu_ctrl_d     = sel_ctrl;
          alu_funct3_d   = sel_funct3;
          alu_funct7_5_d = sel_funct7_5;
          alu_sub_d      = sel_sub;
          gnt_d          = gnt_idx;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d   = alu_result;
        rsp_overflow_d = alu_overflow;
        rsp_id_d       = gnt_q;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Pointer advances past the owner only on completion; explicit wrap
          // handles non-power-of-2 NREQ.
          ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gnt_q          <= '0;
      alu_rs1_q      <= '0;
      alu_rs2_q      <= '0;
      alu_ctrl_q     <= '0;
      alu_funct3_q   <= '0;
      alu_funct7_5_q <= 1'b0;
      alu_sub_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      alu_rs1_q      <= alu_rs1_d;
      alu_rs2_q      <= alu_rs2_d;
      alu_ctrl_q     <= alu_ctrl_d;
      alu_funct3_q   <= alu_funct3_d;
      alu_funct7_5_q <= alu_funct7_5_d;
      alu_sub_q      <= alu_sub_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

  assign alu_rs1      = alu_rs1_q;
  assign alu_rs2      = alu_rs2_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign alu_funct3   = alu_funct3_q;
  assign alu_funct7_5 = alu_funct7_5_q;
  assign alu_sub      = alu_sub_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic rst_n;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT A: NREQ=2 ----------------
  logic [1:0]  req_valid, req_ready, req_funct7_5, req_sub;
  logic [63:0] req_rs1, req_rs2;
  logic [5:0]  req_alu_ctrl, req_funct3;
  logic [31:0] alu_rs1, alu_rs2, alu_result, rsp_result;
  logic [2:0]  alu_ctrl, alu_funct3;
  logic        alu_funct7_5, alu_sub, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_overflow, busy;
  logic [0:0]  rsp_id;
  logic [1:0]  dbg_state;

  // ---------------- DUT B: NREQ=3 ----------------
  logic [2:0]  req_valid3, req_ready3, req_funct7_53, req_sub3;
  logic [95:0] req_rs13, req_rs23;
  logic [8:0]  req_alu_ctrl3, req_funct33;
  logic [31:0] alu_rs13, alu_rs23, alu_result3, rsp_result3;
  logic [2:0]  alu_ctrl3, alu_funct33;
  logic        alu_funct7_53, alu_sub3, alu_overflow3;
  logic        rsp_valid3, rsp_overflow3, busy3;
  logic [1:0]  rsp_id3, dbg_state3;

  // Reference ALU: add/sub with signed overflow.
  function automatic logic [32:0] alu_model(input logic [31:0] a, b, input logic sub);
    logic [31:0] r;
    logic        v;
    r = sub ? a - b : a + b;
    v = sub ? ((a[31] != b[31]) && (r[31] != a[31]))
            : ((a[31] == b[31]) && (r[31] != a[31]));
    return {v, r};
  endfunction

  assign {alu_overflow, alu_result}   = alu_model(alu_rs1, alu_rs2, alu_sub);
  assign {alu_overflow3, alu_result3} = alu_model(alu_rs13, alu_rs23, alu_sub3);

  alu_share_arbiter #(.XLEN(32), .NREQ(2)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_alu_ctrl(req_alu_ctrl), .req_funct3(req_funct3),
    .req_funct7_5(req_funct7_5), .req_sub(req_sub),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_ctrl(alu_ctrl), .alu_funct3(alu_funct3),
    .alu_funct7_5(alu_funct7_5), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .busy(busy), .dbg_state(dbg_state)
  );

  alu_share_arbiter #(.XLEN(32), .NREQ(3)) dut3 (
    .CLK(CLK), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_rs1(req_rs13), .req_rs2(req_rs23),
    .req_alu_ctrl(req_alu_ctrl3), .req_funct3(req_funct33),
    .req_funct7_5(req_funct7_53), .req_sub(req_sub3),
    .alu_rs1(alu_rs13), .alu_rs2(alu_rs23),
    .alu_ctrl(alu_ctrl3), .alu_funct3(alu_funct33),
    .alu_funct7_5(alu_funct7_53), .alu_sub(alu_sub3),
    .alu_result(alu_result3), .alu_overflow(alu_overflow3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id3), .rsp_result(rsp_result3), .rsp_overflow(rsp_overflow3),
    .busy(busy3), .dbg_state(dbg_state3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // funct3 is derived from ctrl and funct7_5 from sub so pass-through of every
  // control field is observable.
  task automatic set_req(input int i, input logic [31:0] a, b,
                         input logic [2:0] ctrl, input logic sub);
    req_rs1[i*32 +: 32]    = a;
    req_rs2[i*32 +: 32]    = b;
    req_alu_ctrl[i*3 +: 3] = ctrl;
    req_funct3[i*3 +: 3]   = ctrl ^ 3'b101;
    req_funct7_5[i]        = sub;
    req_sub[i]             = sub;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_rs1 = '0; req_rs2 = '0; req_alu_ctrl = '0;
    req_funct3 = '0; req_funct7_5 = '0; req_sub = '0;
    req_valid3 = '0; req_rs13 = '0; req_rs23 = '0; req_alu_ctrl3 = '0;
    req_funct33 = '0; req_funct7_53 = '0; req_sub3 = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    // reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_rs1", alu_rs1, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst3_rsp_valid", rsp_valid3, 0);
    rst_n = 1'b1;
    step();

    // 1: single add from req0, rsp_ready high early
    set_req(0, 32'd5, 32'd7, 3'b000, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    check("t1_req_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    check("t1_exec_busy", busy, 1);
    check("t1_exec_state", dbg_state, 1);
    check("t1_exec_ready", req_ready, 0);
    check("t1_exec_rsp_valid", rsp_valid, 0);
    check("t1_alu_rs1", alu_rs1, 5);
    check("t1_alu_funct3", alu_funct3, 3'b101);
    step();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_result", rsp_result, 12);
    check("t1_rsp_ovf", rsp_overflow, 0);
    step();
    check("t1_done_valid", rsp_valid, 0);
    check("t1_done_busy", busy, 0);

    // 2: overflow from req1 (ptr now 1)
    set_req(1, 32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 1'b0);
    req_valid = 2'b10;
    #1;
    check("t2_req_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    check("t2_alu_ctrl", alu_ctrl, 3'b100);
    step();
    check("t2_rsp_result", rsp_result, 32'h8000_0000);
    check("t2_rsp_ovf", rsp_overflow, 1);
    check("t2_rsp_id", rsp_id, 1);
    step();

    // 3: round robin, both held valid, accepts every 3 cycles
    set_req(0, 32'd100, 32'd1, 3'b001, 1'b0);
    set_req(1, 32'd200, 32'd2, 3'b010, 1'b0);
    exp_q = {64'd0, 64'd1, 64'd0, 64'd1};
    req_valid = 2'b11;
    for (int it = 0; it < 4; it++) begin
      logic [63:0] g;
      g = exp_q.pop_front();
      #1;
      check($sformatf("t3_ready_%0d", it), req_ready, (g == 0) ? 2'b01 : 2'b10);
      step();
      check($sformatf("t3_exec_ready_%0d", it), req_ready, 0);
      step();
      check($sformatf("t3_rsp_id_%0d", it), rsp_id, g);
      check($sformatf("t3_rsp_result_%0d", it), rsp_result, (g == 0) ? 101 : 202);
      step();
      if (it == 3) req_valid = '0;
    end

    // 4: backpressure on 10-3; req1 arrives and must wait
    set_req(0, 32'd10, 32'd3, 3'b000, 1'b1);
    set_req(1, 32'd20, 32'd5, 3'b000, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    check("t4_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    check("t4_alu_sub", alu_sub, 1);
    check("t4_alu_funct7_5", alu_funct7_5, 1);
    check("t4_exec_ready", req_ready, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_hold_valid_%0d", c), rsp_valid, 1);
      check($sformatf("t4_hold_result_%0d", c), rsp_result, 7);
      check($sformatf("t4_hold_busy_%0d", c), busy, 1);
      check($sformatf("t4_hold_ready_%0d", c), req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_still_valid", rsp_valid, 1);
    step();
    check("t4_done_valid", rsp_valid, 0);
    check("t4_waiter_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    step();
    check("t4_waiter_id", rsp_id, 1);
    check("t4_waiter_result", rsp_result, 25);
    step();

    // 5: reset during EXEC with ptr=1
    set_req(0, 32'd9, 32'd9, 3'b000, 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    step();
    set_req(1, 32'd33, 32'd1, 3'b011, 1'b0);
    req_valid = 2'b10;
    #1;
    check("t5_pre_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    check("t5_exec_alu_rs1", alu_rs1, 33);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rsp_valid", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_alu_rs1", alu_rs1, 0);
    step();
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("t5_ptr_zero", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    check("t5_req1_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    step();
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_id", rsp_id, 1);
    check("t5_rsp_result", rsp_result, 34);
    step();

    // 6: NREQ=3 wrap
    for (int i = 0; i < 3; i++) begin
      req_rs13[i*32 +: 32] = 32'(1000 + i);
      req_rs23[i*32 +: 32] = 32'd0;
    end
    exp_q = {64'd0, 64'd1, 64'd2, 64'd0};
    req_valid3 = 3'b111;
    for (int it = 0; it < 4; it++) begin
      logic [63:0] g;
      logic [2:0]  oh;
      g = exp_q.pop_front();
      oh = 3'b001 << g;
      #1;
      check($sformatf("t6_ready_%0d", it), req_ready3, oh);
      step();
      step();
      check($sformatf("t6_rsp_id_%0d", it), rsp_id3, g);
      check($sformatf("t6_rsp_result_%0d", it), rsp_result3, 1000 + g);
      step();
      if (it == 3) req_valid3 = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
